rand_matrix_gen: RTL and testbench

- Consumes the 4-bit pseudo-random stream from the LFSR generator and fills an R x C matrix with random elements in 0..MAX_VAL.
- Writes the matrix element by element, in row-major order, to the matrix storage block over a valid/ready write interface.
- Dimensions come from the user or are drawn randomly from the same stream.
- Sits between the LFSR and the matrix storage. The top-level FSM drives it in "generate matrix" mode.

---
 rtl/rand_matrix_gen.sv | 187 ++++++++++++++++++
 tb/tb_rand_matrix_gen.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_matrix_gen.sv
// Fills an R x C matrix with LFSR-derived values in 0..MAX_VAL and streams them row-major to storage.
// First element valid one cycle after the last dimension is known; holds its element on wr_ready=0 and consumes no LFSR sample while stalled.
module rand_matrix_gen #(
  parameter int MAX_DIM   = 5,
  parameter int MAX_VAL   = 9,
  parameter int DIM_RETRY = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dim_rand,
  input  logic [2:0] rows_in,
  input  logic [2:0] cols_in,
  input  logic [3:0] rnd_in,
  output logic       rnd_take,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [3:0] wr_data,
  output logic [2:0] rows_out,
  output logic [2:0] cols_out,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int              RW         = $clog2(DIM_RETRY + 1);
  localparam logic [2:0]      DIM_MAX    = 3'(MAX_DIM);
  localparam logic [3:0]      VAL_MAX    = 4'(MAX_VAL);
  localparam logic [3:0]      VAL_WRAP   = 4'(MAX_VAL + 1);
  localparam logic [RW-1:0]   RETRY_LAST = RW'(DIM_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIM_R,
    S_DIM_C,
    S_FILL,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [2:0]    rows_d, cols_d, row_d, col_d;
  logic [3:0]    data_d;
  logic          vld_d, done_d, err_d;

  logic          manual_ok, rnd_dim_ok, dim_give_up, hs, col_last, elem_last;
  logic [3:0]    elem_val;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= DIM_MAX);
  endfunction

  // MAX_VAL >= 7 guarantees a single subtraction lands in range
  assign elem_val    = (rnd_in > VAL_MAX) ? (rnd_in - VAL_WRAP) : rnd_in;
  assign manual_ok   = dim_ok(rows_in) && dim_ok(cols_in);
  assign rnd_dim_ok  = dim_ok(rnd_in[2:0]);
  assign dim_give_up = (retry_q == RETRY_LAST);
  assign hs          = wr_valid && wr_ready;
  assign col_last    = (wr_col == cols_out - 3'd1);
  assign elem_last   = col_last && (wr_row == rows_out - 3'd1);
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rnd_take = 1'b0;
    retry_d  = retry_q;
    rows_d   = rows_out;
    cols_d   = cols_out;
    row_d    = wr_row;
    col_d    = wr_col;
    data_d   = wr_data;
    vld_d    = wr_valid;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dim_rand) begin
            retry_d = '0;
            state_d = S_DIM_R;
          end else if (manual_ok) begin
            rows_d   = rows_in;
            cols_d   = cols_in;
            row_d    = 3'd0;
            col_d    = 3'd0;
            data_d   = elem_val;
            vld_d    = 1'b1;
            rnd_take = 1'b1;
            state_d  = S_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_DIM_R: begin
        rnd_take = 1'b1;
        if (rnd_dim_ok || dim_give_up) begin
          rows_d  = rnd_dim_ok ? rnd_in[2:0] : DIM_MAX;
          retry_d = '0;
          state_d = S_DIM_C;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end

      S_DIM_C: begin
        rnd_take = 1'b1;
        if (rnd_dim_ok || dim_give_up) begin
          // the accepting sample also seeds element (0,0)
          cols_d  = rnd_dim_ok ? rnd_in[2:0] : DIM_MAX;
          retry_d = '0;
          row_d   = 3'd0;
          col_d   = 3'd0;
          data_d  = elem_val;
          vld_d   = 1'b1;
          state_d = S_FILL;
        end else begin
          retry_d = retry_q + 1'b1;
        end
      end

      S_FILL: begin
        if (hs) begin
          if (elem_last) begin
            vld_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            rnd_take = 1'b1;
            data_d   = elem_val;
            if (col_last) begin
              col_d = 3'd0;
              row_d = wr_row + 3'd1;
            end else begin
              col_d = wr_col + 3'd1;
            end
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_q  <= '0;
      rows_out <= 3'd0;
      cols_out <= 3'd0;
      wr_row   <= 3'd0;
      wr_col   <= 3'd0;
      wr_data  <= 4'd0;
      wr_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      retry_q  <= retry_d;
      rows_out <= rows_d;
      cols_out <= cols_d;
      wr_row   <= row_d;
      wr_col   <= col_d;
      wr_data  <= data_d;
      wr_valid <= vld_d;
      done     <= done_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_rand_matrix_gen.sv
// Scoreboard bench for rand_matrix_gen: expected elements are queued as LFSR values are driven, checked on each write handshake.
module tb_rand_matrix_gen;

  localparam int MAX_VAL = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dim_rand;
  logic [2:0] rows_in;
  logic [2:0] cols_in;
  logic [3:0] rnd_in;
  logic       rnd_take;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [3:0] wr_data;
  logic [2:0] rows_out;
  logic [2:0] cols_out;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] c;
    logic [3:0] d;
  } elem_t;

  elem_t sb[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    n_writes = 0;

  rand_matrix_gen #(.MAX_DIM(5), .MAX_VAL(MAX_VAL), .DIM_RETRY(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dim_rand (dim_rand),
    .rows_in  (rows_in),
    .cols_in  (cols_in),
    .rnd_in   (rnd_in),
    .rnd_take (rnd_take),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .rows_out (rows_out),
    .cols_out (cols_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] fold(input logic [3:0] v);
    int x;
    x = int'(v);
    if (x > MAX_VAL) x = x - (MAX_VAL + 1);
    return 4'(x);
  endfunction

  task automatic push(input int r, input int c, input logic [3:0] v);
    elem_t e;
    e.r = 3'(r);
    e.c = 3'(c);
    e.d = fold(v);
    sb.push_back(e);
  endtask

  // one clock: drive inputs after the edge, optionally check rnd_take mid-cycle
  task automatic cyc(input logic st, input logic [3:0] rnd, input logic rdy, input int exp_take);
    start    = st;
    rnd_in   = rnd;
    wr_ready = rdy;
    @(negedge clk);
    if (exp_take >= 0) check("rnd_take", rnd_take, exp_take);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic fill_from(input int k0, input int n, input int cols);
    for (int k = k0; k < n; k++) begin
      logic [3:0] v;
      v = 4'($urandom_range(15));
      push(k / cols, k % cols, v);
      cyc(1'b0, v, 1'b1, 1);
    end
    cyc(1'b0, 4'hF, 1'b1, 0);
    check("done_pulse", done, 1);
    check("vld_drop", wr_valid, 0);
    cyc(1'b0, 4'h0, 1'b1, -1);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
  endtask

  // write monitor: scoreboard compare on handshake, stall stability
  initial begin
    logic  prev_stall;
    elem_t prev_e;
    elem_t e;
    prev_stall = 1'b0;
    prev_e     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_vld", wr_valid, 1);
          check("stall_row", wr_row, prev_e.r);
          check("stall_col", wr_col, prev_e.c);
          check("stall_data", wr_data, prev_e.d);
        end
        if (wr_valid && !wr_ready) check("stall_take", rnd_take, 0);
        if (wr_valid && wr_ready) begin
          n_writes++;
          if (sb.size() == 0) begin
            check("unexpected_write", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("wr_row", wr_row, e.r);
            check("wr_col", wr_col, e.c);
            check("wr_data", wr_data, e.d);
          end
        end
        prev_stall = wr_valid && !wr_ready;
        prev_e     = {wr_row, wr_col, wr_data};
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] seq1 [6];
    int w0;

    rst      = 1'b1;
    start    = 1'b0;
    dim_rand = 1'b0;
    rows_in  = 3'd0;
    cols_in  = 3'd0;
    rnd_in   = 4'd0;
    wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_vld", wr_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rows", rows_out, 0);
    check("rst_cols", cols_out, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // manual 2x3 with folding
    seq1 = '{4'd3, 4'd12, 4'd9, 4'd15, 4'd0, 4'd10};
    w0 = n_writes;
    rows_in = 3'd2;
    cols_in = 3'd3;
    push(0, 0, seq1[0]);
    cyc(1'b1, seq1[0], 1'b1, 1);
    check("vld_after_start", wr_valid, 1);
    check("busy_fill", busy, 1);
    for (int k = 1; k < 6; k++) begin
      push(k / 3, k % 3, seq1[k]);
      cyc(1'b0, seq1[k], 1'b1, 1);
    end
    cyc(1'b0, 4'hE, 1'b1, 0);
    check("t1_done", done, 1);
    check("t1_vld_off", wr_valid, 0);
    check("t1_busy_done", busy, 1);
    cyc(1'b0, 4'h0, 1'b1, -1);
    check("t1_done_off", done, 0);
    check("t1_busy_off", busy, 0);
    check("t1_rows", rows_out, 2);
    check("t1_cols", cols_out, 3);
    check("t1_writes", n_writes - w0, 6);

    // illegal manual dimensions
    w0 = n_writes;
    for (int i = 0; i < 2; i++) begin
      rows_in = (i == 0) ? 3'd0 : 3'd6;
      cols_in = 3'd3;
      cyc(1'b1, 4'h5, 1'b1, 0);
      check("bad_err", err, 1);
      check("bad_busy", busy, 0);
      check("bad_vld", wr_valid, 0);
      cyc(1'b0, 4'h5, 1'b1, -1);
      check("bad_err_pulse", err, 0);
      check("bad_rows_hold", rows_out, 2);
    end
    check("bad_writes", n_writes - w0, 0);

    // random dimensions: rows 7,0,4 -> 4 ; cols 6,2 -> 2
    w0 = n_writes;
    dim_rand = 1'b1;
    cyc(1'b1, 4'h5, 1'b1, 0);
    cyc(1'b0, 4'h7, 1'b1, 1);
    cyc(1'b0, 4'h8, 1'b1, 1);
    cyc(1'b0, 4'hC, 1'b1, 1);
    check("rnd_rows", rows_out, 4);
    check("rnd_no_vld_yet", wr_valid, 0);
    cyc(1'b0, 4'hE, 1'b1, 1);
    push(0, 0, 4'h2);
    cyc(1'b0, 4'h2, 1'b1, 1);
    check("rnd_cols", cols_out, 2);
    check("rnd_vld", wr_valid, 1);
    fill_from(1, 8, 2);
    check("rnd_writes", n_writes - w0, 8);

    // fallback after 8 rejected row samples
    w0 = n_writes;
    cyc(1'b1, 4'h0, 1'b1, 0);
    repeat (8) cyc(1'b0, 4'h8, 1'b1, 1);
    check("fallback_rows", rows_out, 5);
    push(0, 0, 4'h1);
    cyc(1'b0, 4'h1, 1'b1, 1);
    check("fallback_cols", cols_out, 1);
    fill_from(1, 5, 1);
    check("fallback_writes", n_writes - w0, 5);

    // 1x2 with backpressure 0,0,1,0,1
    w0 = n_writes;
    dim_rand = 1'b0;
    rows_in  = 3'd1;
    cols_in  = 3'd2;
    push(0, 0, 4'hB);
    cyc(1'b1, 4'hB, 1'b0, 1);
    cyc(1'b0, 4'h3, 1'b0, 0);
    cyc(1'b0, 4'h4, 1'b0, 0);
    push(0, 1, 4'hD);
    cyc(1'b0, 4'hD, 1'b1, 1);
    cyc(1'b0, 4'h6, 1'b0, 0);
    cyc(1'b0, 4'h7, 1'b1, 0);
    check("stall_done", done, 1);
    cyc(1'b0, 4'h0, 1'b1, -1);
    check("stall_writes", n_writes - w0, 2);

    // reset during the third element of a 3x3 fill
    w0 = n_writes;
    rows_in = 3'd3;
    cols_in = 3'd3;
    push(0, 0, 4'h1);
    cyc(1'b1, 4'h1, 1'b1, 1);
    push(0, 1, 4'h2);
    cyc(1'b0, 4'h2, 1'b1, 1);
    push(0, 2, 4'h3);
    cyc(1'b0, 4'h3, 1'b1, 1);
    check("pre_rst_col", wr_col, 2);
    wr_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", wr_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rows", rows_out, 0);
    check("mid_rst_pending", sb.size(), 1);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_writes", n_writes - w0, 2);
    w0 = n_writes;
    push(0, 0, 4'h9);
    cyc(1'b1, 4'h9, 1'b1, 1);
    fill_from(1, 9, 3);
    check("post_rst_writes", n_writes - w0, 9);

    // start pulses mid-fill and in the DONE cycle are ignored
    w0 = n_writes;
    rows_in = 3'd2;
    cols_in = 3'd2;
    push(0, 0, 4'h4);
    cyc(1'b1, 4'h4, 1'b1, 1);
    rows_in = 3'd5;
    cols_in = 3'd5;
    push(0, 1, 4'hA);
    cyc(1'b1, 4'hA, 1'b1, 1);
    push(1, 0, 4'h6);
    cyc(1'b1, 4'h6, 1'b1, 1);
    push(1, 1, 4'hF);
    cyc(1'b0, 4'hF, 1'b1, 1);
    cyc(1'b0, 4'h3, 1'b1, 0);
    check("ign_done", done, 1);
    cyc(1'b1, 4'h3, 1'b1, 0);
    check("ign_busy", busy, 0);
    check("ign_vld", wr_valid, 0);
    cyc(1'b0, 4'h0, 1'b1, -1);
    check("ign_busy2", busy, 0);
    check("ign_vld2", wr_valid, 0);
    check("ign_rows", rows_out, 2);
    check("ign_cols", cols_out, 2);
    check("ign_writes", n_writes - w0, 4);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
